// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// A bubble zeroes the control word only; operands and specifiers always advance.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic [31:0]       i_if_id_instr,
  input  logic [DATA_W-1:0] i_if_id_pc4,
  input  logic [DATA_W-1:0] i_rd_data1,
  input  logic [DATA_W-1:0] i_rd_data2,
  input  logic [8:0]        i_ctrl_in,
  output logic              o_stall,
  output logic [8:0]        o_ex_ctrl,
  output logic [DATA_W-1:0] o_ex_pc4,
  output logic [DATA_W-1:0] o_ex_rd1,
  output logic [DATA_W-1:0] o_ex_rd2,
  output logic [DATA_W-1:0] o_ex_imm,
  output logic [4:0]        o_ex_rs,
  output logic [4:0]        o_ex_rt,
  output logic [4:0]        o_ex_rd,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  localparam int MEMREAD_BIT = 4;

  logic [8:0]        r_ex_ctrl;
  logic [DATA_W-1:0] r_ex_pc4;
  logic [DATA_W-1:0] r_ex_rd1;
  logic [DATA_W-1:0] r_ex_rd2;
  logic [DATA_W-1:0] r_ex_imm;
  logic [4:0]        r_ex_rs;
  logic [4:0]        r_ex_rt;
  logic [4:0]        r_ex_rd;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_imm;
  logic              w_stall;
  logic              w_bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign w_rs  = i_if_id_instr[25:21];
  assign w_rt  = i_if_id_instr[20:16];
  assign w_rd  = i_if_id_instr[15:11];
  assign w_imm = {{(DATA_W-16){i_if_id_instr[15]}}, i_if_id_instr[15:0]};

  // $0 is hardwired zero, so a load into it can never create a real dependency
  assign w_stall  = r_ex_ctrl[MEMREAD_BIT] && (r_ex_rt != 5'd0) &&
                    ((r_ex_rt == w_rs) || (r_ex_rt == w_rt));
  assign w_bubble = w_stall || i_flush;

  // ID -> EX boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_ctrl    <= '0;
      r_ex_pc4     <= '0;
      r_ex_rd1     <= '0;
      r_ex_rd2     <= '0;
      r_ex_imm     <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_ex_ctrl <= w_bubble ? 9'd0 : i_ctrl_in;
      r_ex_pc4  <= i_if_id_pc4;
      r_ex_rd1  <= i_rd_data1;
      r_ex_rd2  <= i_rd_data2;
      r_ex_imm  <= w_imm;
      r_ex_rs   <= w_rs;
      r_ex_rt   <= w_rt;
      r_ex_rd   <= w_rd;
      if (w_bubble) r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign o_stall      = w_stall;
  assign o_ex_ctrl    = r_ex_ctrl;
  assign o_ex_pc4     = r_ex_pc4;
  assign o_ex_rd1     = r_ex_rd1;
  assign o_ex_rd2     = r_ex_rd2;
  assign o_ex_imm     = r_ex_imm;
  assign o_ex_rs      = r_ex_rs;
  assign o_ex_rt      = r_ex_rt;
  assign o_ex_rd      = r_ex_rd;
  assign o_bubble_cnt = r_bubble_cnt;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width of register operands, PC+4 and immediate.
REQ-002 Parameter: CNT_W, 16, width of the bubble statistics counter.
REQ-003 clock  in  1  single clock; all state updates on posedge clock.
REQ-004 reset  in  1  asynchronous, active-low; clears all state while 0.
REQ-005 flush  in  1  branch-taken kill of the instruction in decode.
REQ-006 if_id_instr  in  32  decoded instruction word (rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]).
REQ-007 if_id_pc4  in  DATA_W  PC+4 of the decode instruction.
REQ-008 rd_data1, rd_data2  in  DATA_W each  register-file read data for rs and rt.
REQ-009 ctrl_in  in  9  {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]} from main control.
REQ-010 stall  out  1  load-use hazard; combinational; PC and IF/ID hold while 1.
REQ-011 ex_ctrl  out  9  registered control, same field order as ctrl_in.
REQ-012 ex_pc4, ex_rd1, ex_rd2, ex_imm  out  DATA_W each  registered PC+4, operands, sign-extended immediate.
REQ-013 ex_rs, ex_rt, ex_rd  out  5 each  registered register specifiers (for forwarding and RegDst mux).
REQ-014 bubble_cnt  out  CNT_W  number of bubbles inserted since reset.

Function
REQ-015 Hazard: stall SHALL be 1 iff ex_ctrl.MemRead=1 and ex_rt!=0 and (ex_rt==if_id_instr[25:21] or ex_rt==if_id_instr[20:16]); else 0.
REQ-016 stall SHALL depend only on current registered ex_* state and if_id_instr (no dependence on flush).
REQ-017 Normal cycle (stall=0, flush=0): on posedge, all ex_* outputs SHALL capture their inputs; latency exactly 1 cycle.
REQ-018 ex_imm SHALL equal {{(DATA_W-16){instr[15]}}, instr[15:0]} (sign extension).
REQ-019 Bubble (stall=1 or flush=1): on posedge, ex_ctrl SHALL load 9'b0; all datapath and specifier outputs SHALL still capture their inputs.
REQ-020 Simultaneous stall and flush SHALL produce exactly one bubble for that cycle.
REQ-021 bubble_cnt SHALL increment by 1 on every posedge where a bubble is loaded and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-022 Back-to-back load-use: after one bubble, ex_ctrl.MemRead=0, so stall SHALL deassert in the following cycle; a hazard never stalls more than 1 cycle.
REQ-023 Specifier $0 SHALL never raise stall, even when a load targets rt=0.
REQ-024 Register-file write of the same register in the same cycle is resolved by the register file (negedge write); this block performs no bypass.

Reset
REQ-025 While reset=0, all ex_* outputs and bubble_cnt SHALL be 0, independent of clock.
REQ-026 Because ex_ctrl=0 during reset, stall SHALL be 0 during and immediately after reset.
REQ-027 Reset asserted mid-stall SHALL clear state immediately; first posedge after release SHALL perform a normal capture.

Verification
REQ-028 Reset: reset=0 with random inputs, clock toggling -> all outputs 0, stall=0, bubble_cnt=0.
REQ-029 Pass-through: instr=0x8C22FFFC (lw $2,-4($1)), rd_data1=8, ctrl_in=9'h0F0 -> next cycle ex_rs=1, ex_rt=2, ex_imm=0xFFFFFFFC, ex_rd1=8, ex_ctrl=9'h0F0.
REQ-030 Load-use: ex holds lw to $2 (MemRead=1), decode instr=0x00421820 (add $3,$2,$2) -> stall=1; next posedge ex_ctrl=0, bubble_cnt=1; following cycle stall=0.
REQ-031 $0 case: ex holds lw to $0, decode uses rs=0 -> stall=0, no bubble, bubble_cnt unchanged.
REQ-032 Flush with stall: flush=1 concurrent with load-use hazard -> one bubble, bubble_cnt +1 only.
REQ-033 Saturation: CNT_W=2, 5 consecutive flush cycles -> bubble_cnt sequence 1,2,3,3,3.
